// File: rtl/cycle_sequencer_pkg.sv
// cycle_pkg: shared constants for the instruction-cycle sequencer and datapath.
//   Phase codes FETCH/READ/SHIFT/WRITE, condition codes EQcc..ALcc/NVcc,
//   instruction classes, CPSR flag bit indices and a class decoder.
package cycle_pkg;
    localparam logic [1:0] FETCH = 2'b00;
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] SHIFT = 2'b10;
    localparam logic [1:0] WRITE = 2'b11;

    localparam logic [3:0] EQcc = 4'h0;
    localparam logic [3:0] NEcc = 4'h1;
    localparam logic [3:0] CScc = 4'h2;
    localparam logic [3:0] CCcc = 4'h3;
    localparam logic [3:0] MIcc = 4'h4;
    localparam logic [3:0] PLcc = 4'h5;
    localparam logic [3:0] VScc = 4'h6;
    localparam logic [3:0] VCcc = 4'h7;
    localparam logic [3:0] HIcc = 4'h8;
    localparam logic [3:0] LScc = 4'h9;
    localparam logic [3:0] GEcc = 4'hA;
    localparam logic [3:0] LTcc = 4'hB;
    localparam logic [3:0] GTcc = 4'hC;
    localparam logic [3:0] LEcc = 4'hD;
    localparam logic [3:0] ALcc = 4'hE;
    localparam logic [3:0] NVcc = 4'hF;

    localparam int N = 3;
    localparam int Z = 2;
    localparam int C = 1;
    localparam int V = 0;

    typedef enum logic [1:0] {CLS_DP, CLS_LS, CLS_BR, CLS_NOP} instr_class_e;

    // op is ir[27:25]
    function automatic instr_class_e decode_class(input logic [2:0] op);
        return op[2:1] == 2'b00 ? CLS_DP :
               op[2:1] == 2'b01 ? CLS_LS :
               op == 3'b101     ? CLS_BR : CLS_NOP;
    endfunction
endpackage

// File: rtl/cycle_sequencer_if.sv
// cycle_sequencer_if: bundle between the sequencer and imem / datapath / dmem.
//   master (sequencer): in  imem_valid, instr_rdata, alu_flags, dmem_ready
//                       out imem_req, pc, ir, state, exec_en, cpsr_flags,
//                           dmem_req, bf, branchimm, link_we, link_data
//   slave: the same signals with opposite directions.
interface cycle_sequencer_if;
    logic        imem_valid;
    logic [31:0] instr_rdata;
    logic [3:0]  alu_flags;
    logic        dmem_ready;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [1:0]  state;
    logic        exec_en;
    logic [3:0]  cpsr_flags;
    logic        dmem_req;
    logic        bf;
    logic [31:0] branchimm;
    logic        link_we;
    logic [31:0] link_data;

    modport master (
        input  imem_valid, instr_rdata, alu_flags, dmem_ready,
        output imem_req, pc, ir, state, exec_en, cpsr_flags,
               dmem_req, bf, branchimm, link_we, link_data
    );

    modport slave (
        output imem_valid, instr_rdata, alu_flags, dmem_ready,
        input  imem_req, pc, ir, state, exec_en, cpsr_flags,
               dmem_req, bf, branchimm, link_we, link_data
    );
endinterface

// File: rtl/cycle_sequencer_cond_check.sv
// cond_check: combinational condition-field evaluator.
//   in  cond[3:0]  instruction condition field ir[31:28]
//   in  flags[3:0] {N,Z,C,V}
//   out pass       instruction may execute
module cond_check
    import cycle_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic n, z, c, v;

    assign n = flags[N];
    assign z = flags[Z];
    assign c = flags[C];
    assign v = flags[V];

    always_comb begin
        case (cond)
            EQcc:    pass = z;
            NEcc:    pass = !z;
            CScc:    pass = c;
            CCcc:    pass = !c;
            MIcc:    pass = n;
            PLcc:    pass = !n;
            VScc:    pass = v;
            VCcc:    pass = !v;
            HIcc:    pass = c && !z;
            LScc:    pass = !c || z;
            GEcc:    pass = n == v;
            LTcc:    pass = n != v;
            GTcc:    pass = !z && (n == v);
            LEcc:    pass = z || (n != v);
            ALcc:    pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: multicycle FETCH/READ/SHIFT/WRITE control FSM owning PC, IR and CPSR flags.
//   clk, reset (async, active high)
//   bus (cycle_sequencer_if.master): imem handshake, ALU flags, dmem handshake,
//       phase code, exec enable, branch and link outputs
//   SEQ_PERF_CNT_EN: when defined adds cycle_cnt / retired_cnt outputs.
module cycle_sequencer
    import cycle_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic              clk,
    input  logic              reset,
    cycle_sequencer_if.master bus
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       retired_cnt
`endif
);
    logic [1:0]   state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic [3:0]   cpsr_q, cpsr_d;
    logic         exec_q, exec_d;
    logic         pass;
    logic         advance;
    logic         bf;
    logic         link_we;
    instr_class_e cls;
    logic [31:0]  pc_seq;
    logic [31:0]  target;

    cond_check u_cond (
        .cond  (ir_q[31:28]),
        .flags (cpsr_q),
        .pass  (pass)
    );

    assign cls     = decode_class(ir_q[27:25]);
    assign pc_seq  = pc_q + PC_STEP;
    assign target  = pc_q + 32'd8 + {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
    // loads/stores hold WRITE until the data memory completes
    assign advance = state_q == WRITE && (cls != CLS_LS || bus.dmem_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            cpsr_q  <= '0;
            exec_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cpsr_q  <= cpsr_d;
            exec_q  <= exec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cpsr_d  = cpsr_q;
        exec_d  = exec_q;
        case (state_q)
            FETCH: begin
                if (bus.imem_valid) begin
                    ir_d    = bus.instr_rdata;
                    state_d = READ;
                end
            end
            READ: begin
                exec_d  = pass;
                state_d = pass ? SHIFT : FETCH;
                pc_d    = pass ? pc_q : pc_seq;
            end
            SHIFT: begin
                cpsr_d  = (cls == CLS_DP && ir_q[20]) ? bus.alu_flags : cpsr_q;
                state_d = WRITE;
            end
            default: begin
                if (advance) begin
                    exec_d  = 1'b0;
                    state_d = FETCH;
                    pc_d    = cls == CLS_BR ? target : pc_seq;
                end
            end
        endcase
    end

    // imem_req is masked while reset is held so no fetch is requested before release
    always_comb begin
        bf      = state_q == WRITE && cls == CLS_BR;
        link_we = bf && ir_q[24];
    end

    assign bus.imem_req   = state_q == FETCH && !reset;
    assign bus.dmem_req   = state_q == WRITE && cls == CLS_LS;
    assign bus.bf         = bf;
    assign bus.link_we    = link_we;
    assign bus.branchimm  = bf ? target : '0;
    assign bus.link_data  = link_we ? pc_q + 32'd4 : '0;
    assign bus.pc         = pc_q;
    assign bus.ir         = ir_q;
    assign bus.state      = state_q;
    assign bus.exec_en    = exec_q;
    assign bus.cpsr_flags = cpsr_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] retired_cnt_q, retired_cnt_d;
    logic        retire;

    always_comb begin
        retire        = (state_q == READ && !pass) || advance;
        cycle_cnt_d   = cycle_cnt_q + 32'd1;
        retired_cnt_d = retired_cnt_q + {31'd0, retire};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign retired_cnt = retired_cnt_q;
`endif
endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: vector table, reset corner sequence and random program against a reference model.
module tb_cycle_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;

    logic [31:0] m_pc;
    logic [3:0]  m_cpsr;
    int          m_retired;

    cycle_sequencer_if bus ();

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    cycle_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [3:0]  af;
        int          iw;
        int          dw;
        logic [31:0] pc_exp;
        logic [3:0]  cpsr_exp;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // 0 data-processing, 1 load/store, 2 branch, 3 no-op
    function automatic int kind(input logic [31:0] ins);
        if (ins[27:26] == 2'b00) return 0;
        if (ins[27:26] == 2'b01) return 1;
        if (ins[27:25] == 3'b101) return 2;
        return 3;
    endfunction

    task automatic noise();
        bus.alu_flags  = 4'($urandom);
        bus.dmem_ready = 1'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af, input int iw, input int dw);
        bit          ok;
        int          k;
        int          off;
        logic [31:0] tgt;
        ok  = cond_ok(ins[31:28], m_cpsr);
        k   = kind(ins);
        off = {{8{ins[23]}}, ins[23:0]};
        tgt = m_pc + 32'd8 + 32'(off * 4);
        for (int i = 0; i < iw; i++) begin
            bus.imem_valid  = 1'b0;
            bus.instr_rdata = $urandom;
            noise();
            @(negedge clk);
            chk("fetch_wait_state", 32'(bus.state), 32'd0);
            chk("fetch_wait_req", 32'(bus.imem_req), 32'd1);
            tick();
        end
        bus.imem_valid  = 1'b1;
        bus.instr_rdata = ins;
        noise();
        @(negedge clk);
        chk("fetch_state", 32'(bus.state), 32'd0);
        chk("fetch_req", 32'(bus.imem_req), 32'd1);
        chk("fetch_pc", bus.pc, m_pc);
        chk("fetch_cpsr", 32'(bus.cpsr_flags), 32'(m_cpsr));
        chk("fetch_exec", 32'(bus.exec_en), 32'd0);
        tick();
        bus.imem_valid  = 1'($urandom);
        bus.instr_rdata = $urandom;
        noise();
        @(negedge clk);
        chk("read_state", 32'(bus.state), 32'd1);
        chk("read_ir", bus.ir, ins);
        chk("read_exec", 32'(bus.exec_en), 32'd0);
        chk("read_reqs", {bus.imem_req, bus.dmem_req, bus.bf, bus.link_we}, 32'd0);
        tick();
        m_retired++;
        if (!ok) begin
            m_pc = m_pc + 32'd4;
            return;
        end
        bus.alu_flags = af;
        bus.dmem_ready = 1'($urandom);
        @(negedge clk);
        chk("shift_state", 32'(bus.state), 32'd2);
        chk("shift_exec", 32'(bus.exec_en), 32'd1);
        tick();
        if (k == 0 && ins[20]) m_cpsr = af;
        if (k == 1) begin
            for (int i = 0; i < dw; i++) begin
                bus.dmem_ready = 1'b0;
                bus.alu_flags  = 4'($urandom);
                @(negedge clk);
                chk("ls_stall_state", 32'(bus.state), 32'd3);
                chk("ls_stall_req", 32'(bus.dmem_req), 32'd1);
                tick();
            end
            bus.dmem_ready = 1'b1;
        end else begin
            bus.dmem_ready = 1'($urandom);
        end
        bus.alu_flags = 4'($urandom);
        @(negedge clk);
        chk("write_state", 32'(bus.state), 32'd3);
        chk("write_exec", 32'(bus.exec_en), 32'd1);
        chk("write_cpsr", 32'(bus.cpsr_flags), 32'(m_cpsr));
        chk("write_dmem_req", 32'(bus.dmem_req), 32'(k == 1));
        chk("write_bf", 32'(bus.bf), 32'(k == 2));
        chk("write_branchimm", bus.branchimm, k == 2 ? tgt : 32'd0);
        chk("write_link_we", 32'(bus.link_we), 32'(k == 2 && ins[24]));
        chk("write_link_data", bus.link_data, (k == 2 && ins[24]) ? m_pc + 32'd4 : 32'd0);
        tick();
        m_pc = k == 2 ? tgt : m_pc + 32'd4;
    endtask

    initial begin
        vt[0]  = '{"add_al",   32'hE0810002, 4'hF, 0, 0, 32'h0000_0004, 4'h0};
        vt[1]  = '{"add_wait", 32'hE0810002, 4'hF, 2, 0, 32'h0000_0008, 4'h0};
        vt[2]  = '{"sub",      32'hE0410002, 4'h0, 1, 0, 32'h0000_000C, 4'h0};
        vt[3]  = '{"cmp_z",    32'hE1500001, 4'h4, 0, 0, 32'h0000_0010, 4'h4};
        vt[4]  = '{"beq",      32'h0A000002, 4'h0, 0, 0, 32'h0000_0020, 4'h4};
        vt[5]  = '{"bne_sq",   32'h1A000002, 4'h0, 0, 0, 32'h0000_0024, 4'h4};
        vt[6]  = '{"b_fwd",    32'hEA000035, 4'h0, 0, 0, 32'h0000_0100, 4'h4};
        vt[7]  = '{"bl_back",  32'hEBFFFFFE, 4'h0, 0, 0, 32'h0000_0100, 4'h4};
        vt[8]  = '{"ldr_stall",32'hE5910000, 4'hF, 0, 3, 32'h0000_0104, 4'h4};
        vt[9]  = '{"nv_sq",    32'hF0810002, 4'h0, 0, 0, 32'h0000_0108, 4'h4};
        vt[10] = '{"nop_cls",  32'hEC000000, 4'hF, 0, 0, 32'h0000_010C, 4'h4};
        vt[11] = '{"cmp_nv",   32'hE1500001, 4'h9, 0, 0, 32'h0000_0110, 4'h9};
        vt[12] = '{"b_wrap",   32'hEAFFFFB9, 4'h0, 0, 0, 32'hFFFF_FFFC, 4'h9};
        vt[13] = '{"add_wrap", 32'hE0810002, 4'h0, 0, 0, 32'h0000_0000, 4'h9};
        vt[14] = '{"add_ge",   32'hA0810002, 4'h0, 0, 0, 32'h0000_0004, 4'h9};
        vt[15] = '{"adds_lt",  32'hB0910002, 4'hF, 0, 0, 32'h0000_0008, 4'h9};

        reset = 1'b1;
        bus.imem_valid  = 1'b1;
        bus.instr_rdata = 32'hE0810002;
        bus.alu_flags   = 4'hF;
        bus.dmem_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_ir", bus.ir, 32'h0);
        chk("rst_cpsr", 32'(bus.cpsr_flags), 32'd0);
        chk("rst_ctl", {bus.exec_en, bus.imem_req, bus.dmem_req, bus.bf, bus.link_we}, 32'd0);
        chk("rst_branchimm", bus.branchimm, 32'h0);
        chk("rst_link_data", bus.link_data, 32'h0);
        tick();
        reset = 1'b0;
        m_pc = 32'h0;
        m_cpsr = 4'h0;
        m_retired = 0;

        for (int i = 0; i < 16; i++) begin
            run_instr(vt[i].ins, vt[i].af, vt[i].iw, vt[i].dw);
            chk({vt[i].name, "_pc"}, bus.pc, vt[i].pc_exp);
            chk({vt[i].name, "_cpsr"}, 32'(bus.cpsr_flags), 32'(vt[i].cpsr_exp));
            chk({vt[i].name, "_state"}, 32'(bus.state), 32'd0);
            chk({vt[i].name, "_exec"}, 32'(bus.exec_en), 32'd0);
        end

        // reset in the middle of a stalled store
        run_instr(32'hE1500001, 4'h6, 0, 0);
        bus.imem_valid  = 1'b1;
        bus.instr_rdata = 32'hE5810000;
        tick();
        bus.imem_valid = 1'b0;
        tick();
        tick();
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        chk("str_stall_req", 32'(bus.dmem_req), 32'd1);
        chk("str_stall_cpsr", 32'(bus.cpsr_flags), 32'h6);
        #2 reset = 1'b1;
        #1;
        chk("arst_state", 32'(bus.state), 32'd0);
        chk("arst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("arst_pc", bus.pc, 32'h0);
        chk("arst_cpsr", 32'(bus.cpsr_flags), 32'd0);
        chk("arst_exec", 32'(bus.exec_en), 32'd0);
        bus.dmem_ready = 1'b1;
        tick();
        reset = 1'b0;
        m_pc = 32'h0;
        m_cpsr = 4'h0;
        m_retired = 0;
        run_instr(32'hE0810002, 4'h0, 0, 0);
        chk("post_rst_pc", bus.pc, 32'h4);

        for (int t = 0; t < 200; t++) begin
            logic [31:0] ins;
            int          sel;
            ins = $urandom;
            sel = $urandom_range(0, 4);
            case (sel)
                0: ins[27:26] = 2'b00;
                1: ins[27:26] = 2'b01;
                2: ins[27:25] = 3'b101;
                3: ins[27:25] = 3'b100;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) ins[31:28] = 4'hE;
            run_instr(ins, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        end
        chk("rand_final_pc", bus.pc, m_pc);
        chk("rand_final_cpsr", 32'(bus.cpsr_flags), 32'(m_cpsr));
`ifdef SEQ_PERF_CNT_EN
        chk("retired_cnt", retired_cnt, 32'(m_retired));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
